// File: rtl/instr_fetch_unit.sv
// Fetch stage of the multicycle RV32 core: owns the PC, addresses the
// combinational instruction ROM and latches the returned word into IR.
// Optional feature macro: IFU_MISALIGN_TRAP_EN (misaligned PC targets are
// rejected and flagged instead of being silently aligned).
// Handshake: fetch_req is sampled only in IDLE; busy is high for the whole
// FETCH phase; fetch_done pulses for one cycle once ir/pc_instr are valid.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic        pc_wr_en,
    input  logic [1:0]  pc_src,
    input  logic [31:0] branch_target,
    input  logic [31:0] jalr_target,
    output logic [31:0] instr_addr,
    input  logic [31:0] instr_data,
    output logic [31:0] ir,
    output logic [31:0] pc,
    output logic [31:0] pc_instr,
    output logic [31:0] pc_plus4,
    output logic        busy,
    output logic        fetch_done,
    output logic        misalign_err,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t      state;
    state_t      state_next;
    logic [3:0]  wait_cnt;
    logic [31:0] target;
    logic [31:0] pc_load_val;
    logic        pc_upd_en;
    logic        pc_load;
    logic        fetch_allow;
    logic        capture;

    // PC writes are blocked in FETCH so the ROM address is stable during capture
    assign pc_upd_en = pc_wr_en && (state != FETCH);

    // Resolve the candidate next-PC from the control unit's selection
    always_comb begin
        target = pc;
        unique case (pc_src)
            2'b00:   target = pc + 32'd4;
            2'b01:   target = branch_target;
            2'b10:   target = jalr_target & ~32'h1;
            default: target = pc;
        endcase
    end

`ifdef IFU_MISALIGN_TRAP_EN
    logic misalign_q;
    logic misalign_hit;

    assign misalign_hit = pc_upd_en && (target[1:0] != 2'b00);
    assign pc_load      = pc_upd_en && !misalign_hit;
    assign pc_load_val  = target;
    assign fetch_allow  = !misalign_q;
    assign misalign_err = misalign_q;

    // Sticky misalignment flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            misalign_q <= 1'b0;
        end else if (misalign_hit) begin
            misalign_q <= 1'b1;
        end
    end
`else
    assign pc_load      = pc_upd_en;
    assign pc_load_val  = target & ~32'h3;
    assign fetch_allow  = 1'b1;
    assign misalign_err = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        fetch_done = 1'b0;
        unique case (state)
            IDLE: begin
                if (fetch_req && fetch_allow) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                busy = 1'b1;
                if (wait_cnt == 4'd0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                fetch_done = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign capture = (state == FETCH) && (wait_cnt == 4'd0);

    // ROM wait counter: loaded on acceptance, counts down while in FETCH
    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt <= 4'd0;
        end else if (state == IDLE && state_next == FETCH) begin
            wait_cnt <= WAIT_INIT;
        end else if (state == FETCH && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // Program counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc <= RESET_PC;
        end else if (pc_load) begin
            pc <= pc_load_val;
        end
    end

    // Instruction register and its PC, updated only at capture
    always_ff @(posedge clk) begin
        if (!reset) begin
            ir       <= NOP_INSTR;
            pc_instr <= RESET_PC;
        end else if (capture) begin
            ir       <= instr_data;
            pc_instr <= pc;
        end
    end

    assign instr_addr = pc;
    assign pc_plus4   = pc_instr + 32'd4;
    assign state_dbg  = state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: dut_a runs with no ROM wait states,
// dut_b with three. Each DUT reads a shared 64-word ROM model.
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] S_IDLE  = 32'd0;
    localparam logic [31:0] S_FETCH = 32'd1;
    localparam logic [31:0] S_DONE  = 32'd2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [31:0] rom [0:63];

    logic        a_reset, a_fetch_req, a_pc_wr_en;
    logic [1:0]  a_pc_src;
    logic [31:0] a_branch_target, a_jalr_target, a_instr_addr, a_instr_data;
    logic [31:0] a_ir, a_pc, a_pc_instr, a_pc_plus4;
    logic        a_busy, a_fetch_done, a_misalign_err;
    logic [1:0]  a_state;

    logic        b_reset, b_fetch_req, b_pc_wr_en;
    logic [1:0]  b_pc_src;
    logic [31:0] b_branch_target, b_jalr_target, b_instr_addr, b_instr_data;
    logic [31:0] b_ir, b_pc, b_pc_instr, b_pc_plus4;
    logic        b_busy, b_fetch_done, b_misalign_err;
    logic [1:0]  b_state;

    int a_done_cnt = 0;
    int b_done_cnt = 0;
    int snap;

    assign a_instr_data = rom[a_instr_addr[7:2]];
    assign b_instr_data = rom[b_instr_addr[7:2]];

    instr_fetch_unit #(.RESET_PC(32'h0), .WAIT_CYCLES(0), .NOP_INSTR(NOP)) dut_a (
        .clk(clk), .reset(a_reset), .fetch_req(a_fetch_req), .pc_wr_en(a_pc_wr_en),
        .pc_src(a_pc_src), .branch_target(a_branch_target), .jalr_target(a_jalr_target),
        .instr_addr(a_instr_addr), .instr_data(a_instr_data), .ir(a_ir), .pc(a_pc),
        .pc_instr(a_pc_instr), .pc_plus4(a_pc_plus4), .busy(a_busy),
        .fetch_done(a_fetch_done), .misalign_err(a_misalign_err), .state_dbg(a_state)
    );

    instr_fetch_unit #(.RESET_PC(32'h0), .WAIT_CYCLES(3), .NOP_INSTR(NOP)) dut_b (
        .clk(clk), .reset(b_reset), .fetch_req(b_fetch_req), .pc_wr_en(b_pc_wr_en),
        .pc_src(b_pc_src), .branch_target(b_branch_target), .jalr_target(b_jalr_target),
        .instr_addr(b_instr_addr), .instr_data(b_instr_data), .ir(b_ir), .pc(b_pc),
        .pc_instr(b_pc_instr), .pc_plus4(b_pc_plus4), .busy(b_busy),
        .fetch_done(b_fetch_done), .misalign_err(b_misalign_err), .state_dbg(b_state)
    );

    // Independent count of fetch_done pulses per DUT
    always @(negedge clk) begin
        if (a_fetch_done === 1'b1) a_done_cnt <= a_done_cnt + 1;
        if (b_fetch_done === 1'b1) b_done_cnt <= b_done_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete fetch on dut_a (no wait states) from the current pc
    task automatic fetch_a(input logic [31:0] addr);
        a_fetch_req = 1'b1;
        tick();
        a_fetch_req = 1'b0;
        check("fa busy", 32'(a_busy), 32'd1);
        check("fa addr", a_instr_addr, addr);
        tick();
        check("fa ir", a_ir, rom[addr[7:2]]);
        check("fa done", 32'(a_fetch_done), 32'd1);
        check("fa pc_instr", a_pc_instr, addr);
        check("fa pc_plus4", a_pc_plus4, addr + 32'd4);
        tick();
        check("fa done low", 32'(a_fetch_done), 32'd0);
        check("fa idle", 32'(a_state), S_IDLE);
    endtask

    initial begin
        rom[0] = 32'hFFF0_8493;
        for (int i = 1; i < 64; i++) rom[i] = {8'hA5, 8'(i), 16'h0513};

        a_reset = 1'b0; a_fetch_req = 1'b0; a_pc_wr_en = 1'b0; a_pc_src = 2'b00;
        a_branch_target = 32'h0; a_jalr_target = 32'h0;
        b_reset = 1'b0; b_fetch_req = 1'b0; b_pc_wr_en = 1'b0; b_pc_src = 2'b00;
        b_branch_target = 32'h0; b_jalr_target = 32'h0;

        // Step 1: reset values and a single fetch of ROM[0]
        tick();
        tick();
        check("rst ir", a_ir, NOP);
        check("rst pc", a_pc, 32'h0);
        check("rst pc_instr", a_pc_instr, 32'h0);
        check("rst busy", 32'(a_busy), 32'd0);
        check("rst done", 32'(a_fetch_done), 32'd0);
        check("rst misalign", 32'(a_misalign_err), 32'd0);
        check("rst state", 32'(a_state), S_IDLE);
        check("rst b ir", b_ir, NOP);
        a_reset = 1'b1;
        b_reset = 1'b1;
        tick();
        check("idle hold", 32'(a_state), S_IDLE);
        fetch_a(32'h0);
        check("t1 ir value", a_ir, 32'hFFF0_8493);

        // Step 2: twelve sequential fetches with PC+4
        snap = a_done_cnt;
        for (int i = 0; i < 12; i++) begin
            fetch_a(32'(4 * i));
            a_pc_wr_en = 1'b1; a_pc_src = 2'b00;
            tick();
            a_pc_wr_en = 1'b0;
            check("t2 pc step", a_pc, 32'(4 * (i + 1)));
        end
        check("t2 done count", 32'(a_done_cnt - snap), 32'd12);

        // Step 3: branch together with fetch_req in IDLE; fetch reads new pc
        a_pc_wr_en = 1'b1; a_pc_src = 2'b01; a_branch_target = 32'h0000_0020;
        a_fetch_req = 1'b1;
        tick();
        a_pc_wr_en = 1'b0; a_fetch_req = 1'b0;
        check("t3 state", 32'(a_state), S_FETCH);
        check("t3 addr", a_instr_addr, 32'h20);
        tick();
        check("t3 ir", a_ir, rom[8]);
        check("t3 done", 32'(a_fetch_done), 32'd1);
        // PC write honoured while in DONE
        a_pc_wr_en = 1'b1; a_pc_src = 2'b00;
        tick();
        a_pc_wr_en = 1'b0;
        check("t3 done pc wr", a_pc, 32'h24);
        // pc_src=11 holds
        a_pc_wr_en = 1'b1; a_pc_src = 2'b11;
        tick();
        check("t3 hold", a_pc, 32'h24);
        // Wrap at the top of the address space
        a_pc_src = 2'b01; a_branch_target = 32'hFFFF_FFFC;
        tick();
        check("t3 pc top", a_pc, 32'hFFFF_FFFC);
        a_pc_src = 2'b00;
        tick();
        a_pc_wr_en = 1'b0;
        check("t3 wrap", a_pc, 32'h0);

        // Step 4: WAIT_CYCLES=3, requests and PC writes during FETCH are dropped
        snap = b_done_cnt;
        b_fetch_req = 1'b1;
        tick();
        check("t4 accept", 32'(b_state), S_FETCH);
        b_pc_wr_en = 1'b1; b_pc_src = 2'b01; b_branch_target = 32'h0000_0040;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("t4 busy", 32'(b_busy), 32'd1);
            check("t4 ir wait", b_ir, NOP);
            check("t4 pc stable", b_pc, 32'h0);
            check("t4 no done", 32'(b_fetch_done), 32'd0);
        end
        b_pc_wr_en = 1'b0;
        tick();
        check("t4 capture done", 32'(b_fetch_done), 32'd1);
        check("t4 ir", b_ir, 32'hFFF0_8493);
        check("t4 pc", b_pc, 32'h0);
        tick();
        b_fetch_req = 1'b0;
        check("t4 back idle", 32'(b_state), S_IDLE);
        check("t4 done low", 32'(b_fetch_done), 32'd0);
        tick();
        tick();
        check("t4 still idle", 32'(b_state), S_IDLE);
        check("t4 one pulse", 32'(b_done_cnt - snap), 32'd1);

        // Step 6: reset on the second FETCH cycle aborts with no fetch_done
        b_pc_wr_en = 1'b1; b_pc_src = 2'b01; b_branch_target = 32'h0000_0040;
        tick();
        b_pc_wr_en = 1'b0;
        check("t6 pc set", b_pc, 32'h40);
        snap = b_done_cnt;
        b_fetch_req = 1'b1;
        tick();
        b_fetch_req = 1'b0;
        tick();
        check("t6 in fetch", 32'(b_state), S_FETCH);
        b_reset = 1'b0;
        tick();
        b_reset = 1'b1;
        check("t6 state", 32'(b_state), S_IDLE);
        check("t6 ir", b_ir, NOP);
        check("t6 pc", b_pc, 32'h0);
        check("t6 busy", 32'(b_busy), 32'd0);
        for (int k = 0; k < 5; k++) tick();
        check("t6 no pulse", 32'(b_done_cnt - snap), 32'd0);

        // Step 5: JALR bit-0 clear and misalignment handling
        a_pc_wr_en = 1'b1; a_pc_src = 2'b10; a_jalr_target = 32'h0000_0011;
        tick();
        a_pc_wr_en = 1'b0;
        check("t5 jalr", a_pc, 32'h10);
        check("t5 no err", 32'(a_misalign_err), 32'd0);
`ifdef IFU_MISALIGN_TRAP_EN
        a_pc_wr_en = 1'b1; a_pc_src = 2'b10; a_jalr_target = 32'h0000_0012;
        tick();
        a_pc_wr_en = 1'b0;
        check("t5 pc held", a_pc, 32'h10);
        check("t5 err", 32'(a_misalign_err), 32'd1);
        snap = a_done_cnt;
        a_fetch_req = 1'b1;
        tick();
        a_fetch_req = 1'b0;
        check("t5 blocked", 32'(a_state), S_IDLE);
        check("t5 not busy", 32'(a_busy), 32'd0);
        tick();
        tick();
        check("t5 no done", 32'(a_done_cnt - snap), 32'd0);
        check("t5 sticky", 32'(a_misalign_err), 32'd1);
`else
        a_pc_wr_en = 1'b1; a_pc_src = 2'b10; a_jalr_target = 32'h0000_0012;
        tick();
        check("t5 jalr align", a_pc, 32'h10);
        a_pc_src = 2'b01; a_branch_target = 32'h0000_0027;
        tick();
        a_pc_wr_en = 1'b0;
        check("t5 br align", a_pc, 32'h24);
        check("t5 err tied", 32'(a_misalign_err), 32'd0);
        fetch_a(32'h24);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage of the 32-bit multicycle RISC-V CPU.
- Owns the program counter and drives the word address into the combinational instruction ROM.
- Latches the returned word into the instruction register (IR) under a request/done handshake with the control FSM.
- Applies next-PC selection (sequential, branch, JALR) on command from the control unit.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- WAIT_CYCLES, 0, extra cycles held in FETCH before IR capture (range 0-15), for slower ROM macros.
- NOP_INSTR, 32'h0000_0013, IR value after reset (addi x0,x0,0).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- fetch_req  in  1  control FSM requests an instruction fetch
- pc_wr_en  in  1  control FSM commits a new PC
- pc_src  in  2  00 = PC+4, 01 = branch_target, 10 = jalr_target, 11 = hold
- branch_target  in  32  PC-relative target from the ALU/adder
- jalr_target  in  32  rs1+imm from the ALU
- instr_addr  out  32  byte address to the ROM; always equals pc
- instr_data  in  32  ROM read data
- ir  out  32  latched instruction
- pc  out  32  current PC
- pc_instr  out  32  PC of the instruction currently held in ir
- pc_plus4  out  32  pc_instr + 4, for JAL/JALR link
- busy  out  1  high while in FETCH
- fetch_done  out  1  one-cycle pulse after IR capture
- misalign_err  out  1  misaligned PC-target flag (see Optional Feature)

Behaviour:
- Reset (reset==0 at a clk edge) sets these values and aborts any in-flight fetch with no fetch_done:
  - pc = RESET_PC, pc_instr = RESET_PC, ir = NOP_INSTR
  - busy = 0, fetch_done = 0, misalign_err = 0
  - internal wait counter = 0, state = IDLE
- FSM states: IDLE, FETCH, DONE.
- IDLE:
  - fetch_req=1 -> FETCH; the counter loads WAIT_CYCLES.
  - Otherwise stay in IDLE.
- FETCH:
  - busy = 1.
  - If the counter is nonzero, decrement it and stay in FETCH.
  - If the counter is 0, then at that edge: ir <= instr_data, pc_instr <= pc, go to DONE.
  - Capture latency is 1+WAIT_CYCLES cycles from acceptance.
- DONE:
  - fetch_done = 1 for exactly one cycle, busy = 0, then -> IDLE.
  - fetch_req in DONE is ignored; the FSM must re-request from IDLE.
- fetch_req while busy is ignored; it is neither queued nor counted.
- PC update (pc_wr_en=1):
  - Honoured in IDLE and DONE only; ignored in FETCH so the ROM address stays stable during capture.
  - pc_src 00: pc <= pc + 4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
  - pc_src 01: pc <= branch_target.
  - pc_src 10: pc <= jalr_target & ~32'h1 (RISC-V JALR bit-0 clear).
  - pc_src 11: pc unchanged.
- Simultaneous pc_wr_en and fetch_req in IDLE: both take effect at the same edge, and the fetch reads the updated PC (instr_addr = new pc in FETCH).
- ir, pc_instr and pc_plus4 hold their values between fetches.
- pc_plus4 is combinational from pc_instr.
- instr_addr is a direct copy of pc; the ROM uses addr[31:2].

Optional Feature:
- Macro: IFU_MISALIGN_TRAP_EN.
- Defined:
  - A PC write whose resolved target has bits[1:0] != 0 leaves pc unchanged.
  - It sets misalign_err = 1, which is sticky until reset.
  - While misalign_err = 1, fetch_req is ignored and the FSM stays in IDLE.
- Undefined:
  - Target bits[1:0] are forced to 00 before the PC write.
  - misalign_err is tied to 0.

Test Plan:
1. Reset, then fetch_req pulse with ROM word 32'hFFF08493 at address 0 (WAIT_CYCLES=0) -> after reset ir=32'h0000_0013. ir=32'hFFF08493 one cycle after acceptance; fetch_done high the following cycle only; pc_instr=0, pc_plus4=4.
2. Sequential run: fetch, then pc_wr_en with pc_src=00, repeated 12 times -> instr_addr steps 0,4,...,44. Each ir matches the ROM word at that address; exactly 12 fetch_done pulses.
3. pc_wr_en with pc_src=01, branch_target=32'h0000_0020, plus fetch_req in the same IDLE cycle -> FETCH uses instr_addr=32'h20 and ir = ROM[8]. Separately, pc=32'hFFFF_FFFC with pc_src=00 -> pc=0.
4. fetch_req and pc_wr_en asserted during FETCH with WAIT_CYCLES=3 -> capture happens on the 4th cycle. pc is unchanged, the extra request is dropped, and exactly one fetch_done pulse occurs.
5. jalr_target=32'h0000_0011:
   - With IFU_MISALIGN_TRAP_EN undefined -> pc=32'h10.
   - With it defined -> pc=32'h11 & ~1 = 32'h10 (aligned, no error). Then jalr_target=32'h12 -> pc holds, misalign_err=1, and a subsequent fetch_req produces no fetch_done.
6. Reset asserted on the 2nd FETCH cycle (WAIT_CYCLES=3) -> next cycle state IDLE, ir=32'h0000_0013, pc=RESET_PC, with no fetch_done pulse.
